booth_seq_multiplier: RTL and testbench



---
 rtl/booth_seq_multiplier_if.sv | 29 ++
 rtl/booth_seq_multiplier.sv | 92 +++++++++
 tb/tb_booth_seq_multiplier.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_multiplier_if.sv
// Operand/result bundle for booth_seq_multiplier: start request, operands, status and product.
interface booth_seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per clock, WIDTH steps,
// registered signed product with a one-cycle done pulse.
module booth_seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    booth_seq_multiplier_if.slave bus
);
    localparam int unsigned StepW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [StepW-1:0]     step_q, step_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            step_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            step_q    <= step_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        q1_d      = q1_q;
        step_d    = step_q;
        product_d = product_q;

        // Guard bit in A keeps A - M exact even when M = -2^(WIDTH-1).
        case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_q;
            2'b10:   sum = a_q - m_q;
            default: sum = a_q;
        endcase

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = '0;
                    m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                    q_d     = bus.multiplier;
                    q1_d    = 1'b0;
                    step_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d    = {sum[WIDTH], sum[WIDTH:1]};
                q_d    = {sum[0], q_q[WIDTH-1:1]};
                q1_d   = q_q[0];
                step_d = step_q + StepW'(1);
                if (step_q == StepW'(WIDTH - 1)) begin
                    product_d = {a_d[WIDTH-1:0], q_d};
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy    = (state_q == StRun);
    assign bus.done    = (state_q == StDone);
    assign bus.product = product_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and swept checks of booth_seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_booth_seq_multiplier;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    booth_seq_multiplier_if #(.WIDTH(8)) b8 ();
    booth_seq_multiplier_if #(.WIDTH(4)) b4 ();

    booth_seq_multiplier #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    booth_seq_multiplier #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One WIDTH=8 operation from IDLE; returns product, start-edge-to-done edges, busy samples.
    task automatic run8(input logic [7:0] m, input logic [7:0] q, output logic [15:0] p,
                        output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        @(negedge clk);
        b8.start        = 1'b1;
        b8.multiplicand = m;
        b8.multiplier   = q;
        @(posedge clk);
        #1;
        if (b8.busy) busy_n++;
        @(negedge clk);
        b8.start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (b8.done) begin
                lat = i;
                checks++;
                if (b8.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_with_done8: busy=%b required 0", b8.busy);
                end
                break;
            end
            if (b8.busy) busy_n++;
        end
        p = b8.product;
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] m, input logic [3:0] q, output logic [7:0] p,
                        output int lat);
        lat = -1;
        @(negedge clk);
        b4.start        = 1'b1;
        b4.multiplicand = m;
        b4.multiplier   = q;
        @(posedge clk);
        @(negedge clk);
        b4.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (b4.done) begin
                lat = i;
                break;
            end
        end
        p = b4.product;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        b8.start        = 1'b0;
        b8.multiplicand = '0;
        b8.multiplier   = '0;
        b4.start        = 1'b0;
        b4.multiplicand = '0;
        b4.multiplier   = '0;
        #22;
        checks++;
        if (b8.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", b8.busy);
        end
        checks++;
        if (b8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b required 0", b8.done);
        end
        checks++;
        if (b8.product !== 16'h0000) begin
            errors++;
            $display("FAIL reset_product: got %h required 0000", b8.product);
        end
        checks++;
        if (b4.product !== 8'h00) begin
            errors++;
            $display("FAIL reset_product4: got %h required 00", b4.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int          lat;
        int          bn;
        run8(8'd3, 8'd5, p, lat, bn);
        checks++;
        if (p !== 16'h000F) begin
            errors++;
            $display("FAIL basic_product: got %h required 000f", p);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges required 8", lat);
        end
        checks++;
        if (bn != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 8", bn);
        end
    endtask

    task automatic test_signs();
        logic [7:0]  ms  [5] = '{8'hFD, 8'h80, 8'h80, 8'h7F, 8'h00};
        logic [7:0]  qs  [5] = '{8'h05, 8'h80, 8'h7F, 8'h7F, 8'hFF};
        logic [15:0] exp [5] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h3F01, 16'h0000};
        logic [15:0] p;
        int          lat;
        int          bn;
        for (int i = 0; i < 5; i++) begin
            run8(ms[i], qs[i], p, lat, bn);
            checks++;
            if (p !== exp[i]) begin
                errors++;
                $display("FAIL signs_%0d: M=%h Q=%h got %h required %h", i, ms[i], qs[i], p,
                         exp[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int nd = 0;
        int de = -1;
        @(negedge clk);
        b8.start        = 1'b1;
        b8.multiplicand = 8'd10;
        b8.multiplier   = 8'hFD;
        @(posedge clk);
        for (int e = 1; e <= 16; e++) begin
            @(negedge clk);
            b8.start        = (e == 3) || (e == 9);
            b8.multiplicand = 8'(e * 5);
            b8.multiplier   = 8'h81;
            @(posedge clk);
            #1;
            if (b8.done) begin
                nd++;
                de = e;
            end
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL ignored_done_count: got %0d required 1", nd);
        end
        checks++;
        if (de != 8) begin
            errors++;
            $display("FAIL ignored_done_edge: got %0d required 8", de);
        end
        checks++;
        if (b8.product !== 16'hFFE2) begin
            errors++;
            $display("FAIL ignored_product: got %h required ffe2", b8.product);
        end
        checks++;
        if (b8.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_restart: busy=%b required 0", b8.busy);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int nd   = 0;
        @(negedge clk);
        b8.start        = 1'b1;
        b8.multiplicand = 8'd7;
        b8.multiplier   = 8'hFE;
        for (int e = 0; e < 40 && nd < 3; e++) begin
            @(posedge clk);
            #1;
            if (b8.done) begin
                checks++;
                if (b8.product !== 16'hFFF2) begin
                    errors++;
                    $display("FAIL b2b_product_%0d: got %h required fff2", nd, b8.product);
                end
                if (last >= 0) begin
                    checks++;
                    if (e - last != 10) begin
                        errors++;
                        $display("FAIL b2b_spacing_%0d: got %0d required 10", nd, e - last);
                    end
                end
                last = e;
                nd++;
            end
        end
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 3", nd);
        end
        @(negedge clk);
        b8.start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int          lat;
        int          bn;
        @(negedge clk);
        b8.start        = 1'b1;
        b8.multiplicand = 8'd9;
        b8.multiplier   = 8'd9;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (b8.busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b required 1", b8.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b8.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy: got %b required 0", b8.busy);
        end
        checks++;
        if (b8.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done: got %b required 0", b8.done);
        end
        checks++;
        if (b8.product !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_product: got %h required 0000", b8.product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run8(8'd2, 8'd2, p, lat, bn);
        checks++;
        if (p !== 16'h0004) begin
            errors++;
            $display("FAIL midrst_after_product: got %h required 0004", p);
        end
        checks++;
        if (lat != 8) begin
            errors++;
            $display("FAIL midrst_after_latency: got %0d required 8", lat);
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  p4;
        logic [15:0] p8;
        logic [7:0]  m8;
        logic [7:0]  q8;
        int          lat;
        int          bn;
        int          ms;
        int          qs;
        int          r;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ms = (a >= 8) ? a - 16 : a;
                qs = (b >= 8) ? b - 16 : b;
                r  = ms * qs;
                run4(4'(a), 4'(b), p4, lat);
                checks++;
                if (p4 !== r[7:0]) begin
                    errors++;
                    $display("FAIL sweep4_product: M=%0d Q=%0d got %h required %h", ms, qs, p4,
                             r[7:0]);
                end
                checks++;
                if (lat != 4) begin
                    errors++;
                    $display("FAIL sweep4_latency: M=%0d Q=%0d got %0d required 4", ms, qs, lat);
                end
            end
        end
        for (int i = 0; i < 24; i++) begin
            m8 = 8'($urandom_range(0, 255));
            q8 = 8'($urandom_range(0, 255));
            ms = (m8 >= 8'd128) ? int'(m8) - 256 : int'(m8);
            qs = (q8 >= 8'd128) ? int'(q8) - 256 : int'(q8);
            r  = ms * qs;
            run8(m8, q8, p8, lat, bn);
            checks++;
            if (p8 !== r[15:0]) begin
                errors++;
                $display("FAIL sweep8_product: M=%0d Q=%0d got %h required %h", ms, qs, p8,
                         r[15:0]);
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL sweep8_latency: M=%0d Q=%0d got %0d required 8", ms, qs, lat);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signs();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
